pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Detects load-use hazards and inserts one bubble.
- Resolves branch and JR redirects from the EX/MEM outputs and flushes the younger stages.
- Freezes PC, IF/ID, ID/EX and EX/MEM while a multi-cycle data-memory access completes.
- Outputs drive the PC write enable, the PC-source mux and the hold/flush inputs of the stage registers.

Parameters:
- MEM_LAT, 1, data-memory access latency in cycles (legal values 1..15). With 1, no memory stall is ever generated.
- CNT_W, 4, width of the internal memory-wait counter. Must satisfy 2^CNT_W > MEM_LAT.

Ports:
- Clk_in  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- IDEX_MemRead  input  1  instruction in EX is a load.
- IDEX_Rt  input  5  destination register of the load in EX.
- IFID_Rs  input  5  source register rs of the instruction in ID.
- IFID_Rt  input  5  source register rt of the instruction in ID.
- EXMEM_Branch  input  1  instruction in MEM is a branch.
- EXMEM_Zero  input  1  ALU zero flag of the branch in MEM.
- EXMEM_JR  input  1  instruction in MEM is JR.
- EXMEM_MemRead  input  1  load is in MEM.
- EXMEM_MemWrite  input  1  store is in MEM.
- PCWrite  output  1  PC register enable.
- PCSrc_sel  output  2  PC source select: 00 = PC+4, 01 = branch target, 10 = JR target.
- IFID_Write  output  1  IF/ID register enable.
- IFID_Flush  output  1  zero the IF/ID register.
- IDEX_Flush  output  1  zero the ID/EX control bits (bubble).
- IDEX_Hold  output  1  hold the ID/EX register.
- EXMEM_Flush  output  1  zero the EX/MEM control bits.
- EXMEM_Hold  output  1  hold the EX/MEM register.
- MemBusy  output  1  high while a memory stall is in progress.

Behaviour:
- State machine: RUN, MEM_WAIT, RELEASE, encoded in 2 bits. Counter `cnt` is CNT_W bits wide.
- Reset (asynchronous, and also mid-operation): state = RUN, cnt = 0. While Rst is high, outputs are forced to:
  - PCWrite = 1, IFID_Write = 1;
  - PCSrc_sel = 00;
  - all Flush and Hold outputs = 0, MemBusy = 0.
- All outputs are combinational from state and the current inputs (Mealy). Detection and response therefore occur in the same cycle; there is zero added latency.
- Signal definitions:
  - `take_br` = EXMEM_Branch & EXMEM_Zero.
  - `take_jr` = EXMEM_JR.
  - `lu` = IDEX_MemRead & (IDEX_Rt != 0) & (IDEX_Rt == IFID_Rs | IDEX_Rt == IFID_Rt).
  - `memop` = (EXMEM_MemRead | EXMEM_MemWrite) & (MEM_LAT > 1).
- Stall set: PCWrite = 0, IFID_Write = 0, IDEX_Hold = 1, EXMEM_Hold = 1, MemBusy = 1. All flush outputs and PCSrc_sel = 00 during a stall.
- RUN, evaluated in priority order:
  1. `memop`: stall set; cnt <= 1; next state = RELEASE if MEM_LAT == 2, else MEM_WAIT. Redirects and `lu` are ignored this cycle.
  2. Else `take_jr`: PCSrc_sel = 10, PCWrite = 1, IFID_Flush = IDEX_Flush = EXMEM_Flush = 1. JR wins over `take_br` if both are asserted.
  3. Else `take_br`: same as `take_jr` but PCSrc_sel = 01.
  4. Else `lu`: PCWrite = 0, IFID_Write = 0, IDEX_Flush = 1. One bubble; stays in RUN.
  5. Else: normal flow (PCWrite = 1, IFID_Write = 1, everything else 0).
- MEM_WAIT: stall set; cnt <= cnt + 1; when cnt + 1 == MEM_LAT - 1, next state = RELEASE.
- RELEASE:
  - `memop` is not re-triggered (the same access has completed).
  - Items 2–5 of RUN apply; a branch or JR deferred by the stall resolves here.
  - cnt <= 0; next state = RUN.
- Memory stall length is exactly MEM_LAT - 1 cycles per access. Back-to-back memory ops each incur the full stall.
- Register $0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three 32-bit outputs are added, each reset to 0 and wrapping modulo 2^32:
  - StallCycles: increments on each cycle with MemBusy = 1 or a `lu` bubble.
  - FlushEvents: increments on each taken branch or JR.
  - LoadUseEvents: increments on each `lu` bubble.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `pipe_ctrl_pkg` holds:
  - the state encoding constants (RUN = 0, MEM_WAIT = 1, RELEASE = 2);
  - the PCSrc_sel codes (PCSRC_SEQ = 00, PCSRC_BR = 01, PCSRC_JR = 10).
- One sub-module, `load_use_detect`: combinational `lu` comparator.

Test Plan:
- lw $5 in EX with IFID_Rs = 5 -> exactly one cycle of PCWrite = 0, IFID_Write = 0, IDEX_Flush = 1, then normal flow. Repeat with IDEX_Rt = 0 -> no stall.
- Branch and Zero = 1 in MEM -> same cycle PCSrc_sel = 01, PCWrite = 1, IFID_Flush = IDEX_Flush = EXMEM_Flush = 1. With Zero = 0 -> no flush.
- JR and taken branch both asserted, with `lu` also true -> PCSrc_sel = 10, flushes asserted, no `lu` bubble.
- MEM_LAT = 4, sw in MEM -> MemBusy and all holds asserted for 3 cycles, then one RELEASE cycle with normal flow, then RUN.
- MEM_LAT = 3, lw in MEM with a taken branch presented at RELEASE -> 2 stall cycles, then redirect at RELEASE.
- Rst pulsed in the second MEM_WAIT cycle -> outputs go to reset values immediately; after release, state is RUN with cnt = 0. With HAZARD_PERF_CNT_EN defined, all counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and PC-source codes for the pipeline hazard controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        RELEASE  = 2'd2
    } state_t;
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID-stage read of the register a load in EX is about to write ($0 excluded).
module load_use_detect (
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       lu
);
    assign lu = mem_read && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use bubbles, branch/JR redirects and multi-cycle memory stalls.
// Defining HAZARD_PERF_CNT_EN adds StallCycles/FlushEvents/LoadUseEvents counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       Clk_in,
    input  logic       Rst,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_Rt,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       EXMEM_Branch,
    input  logic       EXMEM_Zero,
    input  logic       EXMEM_JR,
    input  logic       EXMEM_MemRead,
    input  logic       EXMEM_MemWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc_sel,
    output logic       IFID_Write,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       IDEX_Hold,
    output logic       EXMEM_Flush,
    output logic       EXMEM_Hold,
    output logic       MemBusy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushEvents,
    output logic [31:0] LoadUseEvents
`endif
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic lu, take_br, take_jr, memop;

    load_use_detect u_lu (
        .mem_read(IDEX_MemRead),
        .ex_rt   (IDEX_Rt),
        .id_rs   (IFID_Rs),
        .id_rt   (IFID_Rt),
        .lu      (lu)
    );

    assign take_br = EXMEM_Branch & EXMEM_Zero;
    assign take_jr = EXMEM_JR;
    assign memop   = (EXMEM_MemRead | EXMEM_MemWrite) && (MEM_LAT > 1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        PCSrc_sel   = PCSRC_SEQ;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        IDEX_Hold   = 1'b0;
        EXMEM_Flush = 1'b0;
        EXMEM_Hold  = 1'b0;
        MemBusy     = 1'b0;
        if (!Rst) begin
            if (state_q == MEM_WAIT || (state_q == RUN && memop)) begin
                PCWrite    = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Hold  = 1'b1;
                EXMEM_Hold = 1'b1;
                MemBusy    = 1'b1;
                if (state_q == RUN) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (MEM_LAT == 2) ? RELEASE : MEM_WAIT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q + 1'b1 == CNT_W'(MEM_LAT - 1)) ? RELEASE : MEM_WAIT;
                end
            end else begin
                // RELEASE completes the held access, so memop is deliberately not re-checked here
                state_d = RUN;
                cnt_d   = '0;
                if (take_jr || take_br) begin
                    PCSrc_sel   = take_jr ? PCSRC_JR : PCSRC_BR;
                    IFID_Flush  = 1'b1;
                    IDEX_Flush  = 1'b1;
                    EXMEM_Flush = 1'b1;
                end else if (lu) begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_Flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, lu_cnt_q, lu_cnt_d;
    logic lu_bubble;
    // A load-use bubble is the only case that flushes ID/EX without flushing EX/MEM
    assign lu_bubble = IDEX_Flush & ~EXMEM_Flush;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(MemBusy | lu_bubble);
        flush_cnt_d = flush_cnt_q + 32'(EXMEM_Flush);
        lu_cnt_d    = lu_cnt_q + 32'(lu_bubble);
    end

    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign StallCycles   = stall_cnt_q;
    assign FlushEvents   = flush_cnt_q;
    assign LoadUseEvents = lu_cnt_q;
`endif
endmodule
